combo_lock_ng: RTL and testbench

Parametrised next-generation keypad combination lock. Password length is set by parameter, and all keypad, enter and rst presses are edge-detected synchronously. Entry length is enforced, and repeated wrong entries trigger a timed lockout. The block sits between the debounced 10-key keypad front end and the door-actuator/status logic.

---
 rtl/combo_lock_ng.sv | 182 ++++++++++++++++++
 tb/tb_combo_lock_ng.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/combo_lock_ng.sv
// Parametrised keypad combination lock: edge-detected BCD digit entry, length-checked
// submit, password reprogramming while unlocked, and a timed lockout after repeated misses.
module combo_lock_ng #(
   parameter int unsigned DIGITS         = 4,
   parameter int unsigned MAX_TRIES      = 3,
   parameter int unsigned LOCKOUT_CYCLES = 1024
) (
   input  logic                          clk,
   input  logic                          hard_rst,
   input  logic                          enter,
   input  logic                          rst,
   input  logic                          clr,
   input  logic [9:0]                    keypad,
   output logic                          unlock,
   output logic                          incorrect,
   output logic                          lockout,
   output logic [$clog2(DIGITS+1)-1:0]   digit_count,
   output logic [4*DIGITS-1:0]           try_monitor
);

   localparam int unsigned PW = 4 * DIGITS;
   localparam int unsigned CW = $clog2(DIGITS + 1);
   localparam int unsigned FW = $clog2(MAX_TRIES + 1);
   localparam int unsigned TW = $clog2(LOCKOUT_CYCLES);

   typedef enum logic [1:0] {
      ST_LOCKED   = 2'd0,
      ST_UNLOCKED = 2'd1,
      ST_PROG     = 2'd2,
      ST_LOCKOUT  = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   pw_q, pw_d;
   logic [PW-1:0]   try_q, try_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [FW-1:0]   fail_q, fail_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            incorrect_d;

   logic [9:0]      keypad_q;
   logic            enter_q, rst_q;
   logic            enter_p_q, rst_p_q;

   logic [3:0]      key_digit_c;
   logic            key_press_c;
   logic            entry_full_c;
   logic [PW-1:0]   try_shift_c;
   logic [FW-1:0]   fail_inc_c;

   // A digit is accepted only on the first one-hot cycle after a non-one-hot cycle.
   always_comb begin
      key_digit_c = '0;
      for (int i = 0; i < 10; i++) begin
         if (keypad[i]) key_digit_c = 4'(i);
      end
   end

   assign key_press_c  = $onehot(keypad) && !$onehot(keypad_q);
   assign entry_full_c = (cnt_q == CW'(DIGITS));
   assign try_shift_c  = PW'({try_q, key_digit_c});
   assign fail_inc_c   = (fail_q == FW'(MAX_TRIES)) ? fail_q : fail_q + FW'(1);

   // Next-state and datapath decisions; priority within a state is clr > enter_p > key.
   always_comb begin
      state_d     = state_q;
      pw_d        = pw_q;
      try_d       = try_q;
      cnt_d       = cnt_q;
      fail_d      = fail_q;
      timer_d     = timer_q;
      incorrect_d = 1'b0;

      case (state_q)
         ST_LOCKED: begin
            if (clr) begin
               try_d = '0;
               cnt_d = '0;
            end else if (enter_p_q) begin
               try_d = '0;
               cnt_d = '0;
               if (entry_full_c && (try_q == pw_q)) begin
                  state_d = ST_UNLOCKED;
                  fail_d  = '0;
               end else begin
                  incorrect_d = 1'b1;
                  fail_d      = fail_inc_c;
                  if (fail_inc_c == FW'(MAX_TRIES)) begin
                     state_d = ST_LOCKOUT;
                     timer_d = TW'(LOCKOUT_CYCLES - 1);
                  end
               end
            end else if (key_press_c && !entry_full_c) begin
               try_d = try_shift_c;
               cnt_d = cnt_q + CW'(1);
            end
         end

         ST_UNLOCKED: begin
            if (enter_p_q) begin
               state_d = ST_LOCKED;
            end else if (rst_p_q) begin
               state_d = ST_PROG;
               try_d   = '0;
               cnt_d   = '0;
            end
         end

         ST_PROG: begin
            if (clr) begin
               try_d = '0;
               cnt_d = '0;
            end else if (enter_p_q) begin
               try_d = '0;
               cnt_d = '0;
               if (entry_full_c) begin
                  pw_d    = try_q;
                  state_d = ST_LOCKED;
               end else begin
                  incorrect_d = 1'b1;
               end
            end else if (key_press_c && !entry_full_c) begin
               try_d = try_shift_c;
               cnt_d = cnt_q + CW'(1);
            end
         end

         ST_LOCKOUT: begin
            // Timer runs LOCKOUT_CYCLES-1 down to 0, giving exactly LOCKOUT_CYCLES cycles here.
            if (timer_q == '0) begin
               state_d = ST_LOCKED;
               fail_d  = '0;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end

         default: begin
            state_d = ST_LOCKED;
         end
      endcase
   end

   // State, edge-detect history and registered outputs; history updates in every state.
   always_ff @(posedge clk) begin
      if (hard_rst) begin
         state_q   <= ST_LOCKED;
         pw_q      <= '0;
         try_q     <= '0;
         cnt_q     <= '0;
         fail_q    <= '0;
         timer_q   <= '0;
         keypad_q  <= '0;
         enter_q   <= 1'b0;
         rst_q     <= 1'b0;
         enter_p_q <= 1'b0;
         rst_p_q   <= 1'b0;
         unlock    <= 1'b0;
         incorrect <= 1'b0;
         lockout   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pw_q      <= pw_d;
         try_q     <= try_d;
         cnt_q     <= cnt_d;
         fail_q    <= fail_d;
         timer_q   <= timer_d;
         keypad_q  <= keypad;
         enter_q   <= enter;
         rst_q     <= rst;
         enter_p_q <= enter & ~enter_q;
         rst_p_q   <= rst & ~rst_q;
         unlock    <= (state_d == ST_UNLOCKED) || (state_d == ST_PROG);
         incorrect <= incorrect_d;
         lockout   <= (state_d == ST_LOCKOUT);
      end
   end

   assign digit_count = cnt_q;
   assign try_monitor = try_q;

endmodule

// File: tb/tb_combo_lock_ng.sv
// Bench for combo_lock_ng: directed scenarios plus random traffic, every cycle scored
// against a queue-based behavioural model of the lock.
module tb_combo_lock_ng;

   localparam int DIGITS         = 4;
   localparam int MAX_TRIES      = 3;
   localparam int LOCKOUT_CYCLES = 16;
   localparam int PW             = 4 * DIGITS;
   localparam int CW             = $clog2(DIGITS + 1);

   localparam int M_LOCKED   = 0;
   localparam int M_UNLOCKED = 1;
   localparam int M_PROG     = 2;
   localparam int M_LOCKOUT  = 3;

   logic          clk = 1'b0;
   logic          hard_rst;
   logic          enter, rst, clr;
   logic [9:0]    keypad;
   logic          unlock, incorrect, lockout;
   logic [CW-1:0] digit_count;
   logic [PW-1:0] try_monitor;

   combo_lock_ng #(
      .DIGITS         (DIGITS),
      .MAX_TRIES      (MAX_TRIES),
      .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
   ) dut (
      .clk         (clk),
      .hard_rst    (hard_rst),
      .enter       (enter),
      .rst         (rst),
      .clr         (clr),
      .keypad      (keypad),
      .unlock      (unlock),
      .incorrect   (incorrect),
      .lockout     (lockout),
      .digit_count (digit_count),
      .try_monitor (try_monitor)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          unlock;
      logic          incorrect;
      logic          lockout;
      logic [CW-1:0] cnt;
      logic [PW-1:0] tryv;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Behavioural model: entry and password kept as digit lists.
   int mode;
   int entry[$];
   int pw[$];
   int fails;
   int lo_left;
   bit prev_oh, prev_en, prev_rs, pend_en, pend_rs;

   function automatic bit entry_matches();
      if (entry.size() != pw.size()) return 1'b0;
      foreach (entry[i]) if (entry[i] != pw[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [PW-1:0] pack_entry();
      logic [PW-1:0] v = '0;
      foreach (entry[i]) v = (v << 4) | PW'(entry[i]);
      return v;
   endfunction

   task automatic model_step(input logic [9:0] kp, input logic en, input logic rs,
                             input logic cl, input logic hr);
      exp_t e;
      bit   oh, press, inc;
      int   dig;
      inc = 1'b0;
      if (hr) begin
         mode = M_LOCKED;
         entry.delete();
         pw.delete();
         repeat (DIGITS) pw.push_back(0);
         fails = 0; lo_left = 0;
         prev_oh = 0; prev_en = 0; prev_rs = 0; pend_en = 0; pend_rs = 0;
      end else begin
         oh    = ($countones(kp) == 1);
         press = oh && !prev_oh;
         dig   = 0;
         for (int i = 0; i < 10; i++) if (kp[i]) dig = i;
         case (mode)
            M_LOCKED: begin
               if (cl) entry.delete();
               else if (pend_en) begin
                  if (entry.size() == DIGITS && entry_matches()) begin
                     mode = M_UNLOCKED; fails = 0;
                  end else begin
                     inc = 1'b1;
                     if (fails < MAX_TRIES) fails++;
                     if (fails == MAX_TRIES) begin
                        mode = M_LOCKOUT; lo_left = LOCKOUT_CYCLES;
                     end
                  end
                  entry.delete();
               end else if (press && entry.size() < DIGITS) entry.push_back(dig);
            end
            M_UNLOCKED: begin
               if (pend_en) mode = M_LOCKED;
               else if (pend_rs) begin mode = M_PROG; entry.delete(); end
            end
            M_PROG: begin
               if (cl) entry.delete();
               else if (pend_en) begin
                  if (entry.size() == DIGITS) begin
                     pw = entry; mode = M_LOCKED;
                  end else inc = 1'b1;
                  entry.delete();
               end else if (press && entry.size() < DIGITS) entry.push_back(dig);
            end
            default: begin
               lo_left--;
               if (lo_left == 0) begin mode = M_LOCKED; fails = 0; end
            end
         endcase
         pend_en = en && !prev_en;
         pend_rs = rs && !prev_rs;
         prev_en = en; prev_rs = rs; prev_oh = oh;
      end
      e.unlock    = (mode == M_UNLOCKED) || (mode == M_PROG);
      e.incorrect = inc;
      e.lockout   = (mode == M_LOCKOUT);
      e.cnt       = CW'(entry.size());
      e.tryv      = pack_entry();
      exp_q.push_back(e);
   endtask

   // Monitor: every output cycle is popped and compared, decoupled from the driver.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (unlock !== e.unlock || incorrect !== e.incorrect || lockout !== e.lockout ||
                digit_count !== e.cnt || try_monitor !== e.tryv) begin
               n_bad++;
               $display("FAIL cycle_outputs t=%0t: got unl=%b inc=%b lo=%b cnt=%0d try=%h, required unl=%b inc=%b lo=%b cnt=%0d try=%h",
                        $time, unlock, incorrect, lockout, digit_count, try_monitor,
                        e.unlock, e.incorrect, e.lockout, e.cnt, e.tryv);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // One clock of stimulus: drive at the falling edge, return at the next falling edge.
   task automatic step(input logic [9:0] kp, input logic en, input logic rs,
                       input logic cl, input logic hr);
      keypad = kp; enter = en; rst = rs; clr = cl; hard_rst = hr;
      model_step(kp, en, rs, cl, hr);
      @(negedge clk);
   endtask

   task automatic idle();
      step(10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic press(input int d, input int hold);
      repeat (hold) step(10'(1 << d), 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
   endtask

   task automatic pulse_enter();
      step(10'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle();
   endtask

   task automatic pulse_rst();
      step(10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle();
   endtask

   task automatic enter_code(input logic [15:0] code);
      for (int i = 3; i >= 0; i--) press(int'(code[4*i +: 4]), 1);
      pulse_enter();
   endtask

   task automatic hard_reset();
      step(10'd0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin : driver
      int n;
      int guard;
      int sel;
      int code[$];
      keypad = '0; enter = 0; rst = 0; clr = 0; hard_rst = 1'b1;
      @(negedge clk);
      hard_reset();
      hard_reset();
      check("reset_unlock", 32'(unlock), 32'd0);
      check("reset_lockout", 32'(lockout), 32'd0);
      check("reset_count", 32'(digit_count), 32'd0);
      check("reset_try", 32'(try_monitor), 32'd0);

      // Default password of zeros unlocks, two edges after enter rises.
      enter_code(16'h0000);
      check("t1_unlock", 32'(unlock), 32'd1);
      check("t1_incorrect", 32'(incorrect), 32'd0);

      // Reprogram to 1234, relock, reopen, then a wrong code.
      pulse_rst();
      enter_code(16'h1234);
      check("t2_locked_after_prog", 32'(unlock), 32'd0);
      enter_code(16'h1234);
      check("t2_unlock_new_pw", 32'(unlock), 32'd1);
      pulse_enter();
      check("t2_relock", 32'(unlock), 32'd0);
      for (int i = 0; i < 4; i++) press(0, 1);
      step(10'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle();
      check("t2_incorrect_pulse", 32'(incorrect), 32'd1);
      idle();
      check("t2_incorrect_single", 32'(incorrect), 32'd0);

      // Held key gives one digit; extra digits are dropped; clr empties.
      press(7, 20);
      press(1, 1); press(2, 1); press(3, 1); press(9, 1); press(5, 1);
      check("t3_count_full", 32'(digit_count), 32'd4);
      check("t3_try_7123", 32'(try_monitor), 32'h7123);
      step(10'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("t3_clr_try", 32'(try_monitor), 32'd0);
      check("t3_clr_count", 32'(digit_count), 32'd0);

      // Multi-key ignored; key coinciding with enter_p is discarded.
      step(10'b0000000110, 1'b0, 1'b0, 1'b0, 1'b0);
      step(10'b0000000110, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      check("t4_multikey", 32'(digit_count), 32'd0);
      press(5, 1);
      step(10'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(10'(1 << 3), 1'b0, 1'b0, 1'b0, 1'b0);
      check("t4_enter_beats_key_inc", 32'(incorrect), 32'd1);
      check("t4_enter_beats_key_cnt", 32'(digit_count), 32'd0);
      idle();

      // Three misses trigger a lockout of exactly LOCKOUT_CYCLES cycles.
      hard_reset();
      check("t5_reset_unlock", 32'(unlock), 32'd0);
      for (int k = 0; k < 3; k++) enter_code(16'h1111);
      check("t5_lockout_on", 32'(lockout), 32'd1);
      check("t5_third_incorrect", 32'(incorrect), 32'd1);
      n = 1;
      guard = 0;
      while (lockout === 1'b1 && guard < 100) begin
         if (guard < 8) step(10'(1 << (guard % 10)), guard[0], guard[1], guard[2], 1'b0);
         else idle();
         guard++;
         if (lockout === 1'b1) n++;
      end
      check("t5_dwell", 32'(n), 32'(LOCKOUT_CYCLES));
      enter_code(16'h0000);
      check("t5_unlock_after", 32'(unlock), 32'd1);

      // Reset mid-PROG restores the zero password; short entry stays in PROG.
      pulse_rst();
      enter_code(16'h4321);
      enter_code(16'h4321);
      check("t6_unlock_4321", 32'(unlock), 32'd1);
      pulse_rst();
      press(1, 1); press(2, 1);
      check("t6_prog_two", 32'(digit_count), 32'd2);
      hard_reset();
      check("t6_rst_unlock", 32'(unlock), 32'd0);
      check("t6_rst_count", 32'(digit_count), 32'd0);
      enter_code(16'h0000);
      check("t6_pw_zero", 32'(unlock), 32'd1);
      pulse_rst();
      press(9, 1); press(8, 1); press(7, 1);
      pulse_enter();
      check("t6_short_incorrect", 32'(incorrect), 32'd1);
      check("t6_short_stay_prog", 32'(unlock), 32'd1);
      enter_code(16'h5555);
      check("t6_commit_locked", 32'(unlock), 32'd0);
      for (int k = 0; k < 3; k++) enter_code(16'h0000);
      check("t6_lockout_again", 32'(lockout), 32'd1);
      idle(); idle(); idle();
      hard_reset();
      check("t6_rst_lockout", 32'(lockout), 32'd0);
      enter_code(16'h0000);
      check("t6_unlock_after_rst", 32'(unlock), 32'd1);

      // Random traffic scored by the model every cycle.
      for (int it = 0; it < 1200; it++) begin
         sel = int'($urandom_range(0, 19));
         if (sel <= 7) press(int'($urandom_range(0, 9)), int'($urandom_range(1, 3)));
         else if (sel <= 9) pulse_enter();
         else if (sel <= 11) pulse_rst();
         else if (sel == 12) step(10'd0, 1'b0, 1'b0, 1'b1, 1'b0);
         else if (sel <= 15) begin
            code = pw;
            foreach (code[i]) press(code[i], 1);
            pulse_enter();
         end else if (sel <= 18)
            step(10'($urandom), ($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0, 1'b0);
         else if (($urandom % 4) == 0) hard_reset();
         else idle();
      end

      idle();
      @(posedge clk);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
